// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a burst requester and pulse_train_gen.
// Names carry the generator's view: i_* flow into it, o_* flow out of it.
interface pulse_train_gen_if #(
  parameter int CNT_W = 2,
  parameter int GAP_W = 4
);
  logic             i_start;
  logic [CNT_W-1:0] i_count;
  logic [GAP_W-1:0] i_gap;
  logic             o_x;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_remaining;

  modport master (
    output i_start, i_count, i_gap,
    input  o_x, o_busy, o_done, o_remaining
  );

  modport slave (
    input  i_start, i_count, i_gap,
    output o_x, o_busy, o_done, o_remaining
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Emits a burst of single-cycle pulses on x separated by a programmable idle gap,
// then a one-cycle done strobe. All outputs are registered alongside the state.
module pulse_train_gen #(
  parameter int CNT_W = 2,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  pulse_train_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_remaining;
  logic [GAP_W-1:0] r_gapL;
  logic [GAP_W-1:0] r_gapCnt;
  logic             r_x;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_remDec;

  assign w_remDec = r_rem - CNT_W'(1);

  // r_rem drops as each pulse ends; r_remaining (visible) drops only when the next pulse starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_remaining <= '0;
      r_gapL      <= '0;
      r_gapCnt    <= '0;
      r_x         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_x    <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_rem       <= bus.i_count;
            r_remaining <= bus.i_count;
            r_gapL      <= bus.i_gap;
            if (bus.i_count != '0) begin
              r_state <= S_PULSE;
              r_x     <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_PULSE: begin
          r_rem <= w_remDec;
          if (w_remDec == '0) begin
            r_state     <= S_DONE;
            r_remaining <= '0;
            r_x         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (r_gapL == '0) begin
            r_state     <= S_PULSE;
            r_remaining <= w_remDec;
            r_x         <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state  <= S_GAP;
            r_gapCnt <= r_gapL;
            r_x      <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_GAP: begin
          r_gapCnt <= r_gapCnt - GAP_W'(1);
          if (r_gapCnt == GAP_W'(1)) begin
            r_state     <= S_PULSE;
            r_remaining <= r_rem;
            r_x         <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_remaining <= '0;
          r_x         <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_x     <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_x         = r_x;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_remaining = r_remaining;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: a burst-offset arithmetic model checked every cycle,
// directed literal scenarios, a downstream 2-bit counter model and random traffic.
`timescale 1ns/1ps
module tb_pulse_train_gen;
  localparam int CNT_W = 2;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compareCount = 0;
  int mismatchCount = 0;

  pulse_train_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: position inside the burst is an offset t from the accepting edge,
  // and every output follows from t, the latched count and the latched gap.
  int  edgeNum = 0;
  int  burstEdge = 0;
  int  bCount = 0;
  int  bGap = 0;
  int  burstLen = 0;
  int  offs = 0;
  bit  active = 0;
  bit  modelValid = 0;
  logic             expX = 0;
  logic             expBusy = 0;
  logic             expDone = 0;
  logic [CNT_W-1:0] expRem = '0;

  always @(posedge clk) begin
    edgeNum++;
    if (reset) begin
      active = 0;
      modelValid = 1;
    end else begin
      if (active && (edgeNum - burstEdge) > burstLen + 1) active = 0;
      if (!active && bus.i_start) begin
        active    = 1;
        burstEdge = edgeNum;
        bCount    = int'(bus.i_count);
        bGap      = int'(bus.i_gap);
        burstLen  = (bCount == 0) ? 0 : bCount + (bCount - 1) * bGap;
      end
    end
    expX = 0; expBusy = 0; expDone = 0; expRem = '0;
    if (active) begin
      offs = edgeNum - burstEdge + 1;
      if (offs <= burstLen) begin
        expBusy = 1;
        expX    = (((offs - 1) % (bGap + 1)) == 0);
        expRem  = CNT_W'(bCount - (offs - 1) / (bGap + 1));
      end else if (offs == burstLen + 1) begin
        expDone = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (modelValid) begin
      cmp("model_x",         {7'd0, bus.o_x},    {7'd0, expX});
      cmp("model_busy",      {7'd0, bus.o_busy}, {7'd0, expBusy});
      cmp("model_done",      {7'd0, bus.o_done}, {7'd0, expDone});
      cmp("model_remaining", 8'(bus.o_remaining), 8'(expRem));
    end
  end

  // Downstream 2-bit event counter fed by x; z fires on a pulse while it sits at 3.
  int dsCount = 0;
  int zSeen = 0;
  always @(posedge clk) begin
    if (bus.o_x === 1'b1) begin
      if (dsCount == 3) zSeen = zSeen + 1;
      dsCount = (dsCount + 1) % 4;
    end
  end

  task automatic applyStimulus(input logic s, input int c, input int g, input logic r);
    @(negedge clk);
    bus.i_start = s;
    bus.i_count = CNT_W'(c);
    bus.i_gap   = GAP_W'(g);
    reset       = r;
  endtask

  task automatic checkOutput(input string name, input int n, input int ex, input int eb,
                             input int ed, input int er);
    cmp($sformatf("%s_x_c%0d", name, n),    {7'd0, bus.o_x},    8'(ex));
    cmp($sformatf("%s_busy_c%0d", name, n), {7'd0, bus.o_busy}, 8'(eb));
    cmp($sformatf("%s_done_c%0d", name, n), {7'd0, bus.o_done}, 8'(ed));
    cmp($sformatf("%s_rem_c%0d", name, n),  8'(bus.o_remaining), 8'(er));
  endtask

  int t1X[9] = '{1,0,0,1,0,0,1,0,0};
  int t1B[9] = '{1,1,1,1,1,1,1,0,0};
  int t1D[9] = '{0,0,0,0,0,0,0,1,0};
  int t1R[9] = '{3,3,3,2,2,2,1,0,0};
  int t2X[5] = '{1,1,1,0,0};
  int t2B[5] = '{1,1,1,0,0};
  int t2D[5] = '{0,0,0,1,0};
  int t2R[5] = '{3,2,1,0,0};
  int t3X[7] = '{1,0,0,0,1,0,0};
  int t3B[7] = '{1,1,1,1,1,0,0};
  int t3D[7] = '{0,0,0,0,0,1,0};
  int t3R[7] = '{2,2,2,2,1,0,0};
  int t4X[8] = '{1,0,0,0,0,0,1,0};
  int t4B[8] = '{1,1,1,0,0,0,1,0};
  int t4D[8] = '{0,0,0,0,0,0,0,1};
  int t4R[8] = '{3,3,3,0,0,0,1,0};

  initial begin
    bus.i_start = 1'b0;
    bus.i_count = '0;
    bus.i_gap   = '0;

    // Two reset edges; the start coinciding with reset must be ignored.
    applyStimulus(1, 3, 2, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_hold", 0, 0, 0, 0, 0);

    // count=3, gap=2
    applyStimulus(1, 3, 2, 0);
    for (int n = 1; n <= 9; n++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("c3g2", n, t1X[n-1], t1B[n-1], t1D[n-1], t1R[n-1]);
    end

    // count=3, gap=0 with the downstream counter starting from 00
    dsCount = 0;
    zSeen = 0;
    applyStimulus(1, 3, 0, 0);
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("c3g0", n, t2X[n-1], t2B[n-1], t2D[n-1], t2R[n-1]);
    end
    cmp("downstream_count", 8'(dsCount), 8'd3);
    cmp("downstream_z", 8'(zSeen), 8'd0);

    // count=0: immediate done, no pulse
    applyStimulus(1, 0, 5, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("c0", 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("c0", 2, 0, 0, 0, 0);

    // second start during a burst is ignored
    applyStimulus(1, 2, 3, 0);
    for (int n = 1; n <= 7; n++) begin
      applyStimulus(n == 2, (n == 2) ? 3 : 2, 3, 0);
      checkOutput("ignore", n, t3X[n-1], t3B[n-1], t3D[n-1], t3R[n-1]);
    end

    // reset mid-burst, then a fresh single-pulse burst
    applyStimulus(1, 3, 4, 0);
    for (int n = 1; n <= 8; n++) begin
      applyStimulus(n == 6, (n == 6) ? 1 : 3, 4, n == 3);
      checkOutput("midreset", n, t4X[n-1], t4B[n-1], t4D[n-1], t4R[n-1]);
    end

    // Random traffic; the per-cycle model compare covers it.
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(0, 2)),
                    $urandom_range(0, 79) == 0);
    end
    for (int n = 0; n < 40; n++) applyStimulus(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
